usb_epp_host: RTL and testbench
===============================

# usb_epp_host

Host-side (initiator) engine for the Digilent EPP USB port protocol, the counterpart of our EPP peripheral driver. It accepts one address/data read or write command at a time from an internal requester and generates the EPP strobes (`usb_write`, `usb_astb`, `usb_dstb`), drives or samples the 8-bit data bus, and handshakes on `usb_wait`. It returns read data or a timeout status. It serves as the host in board-to-board links and as the bus-functional driver in peripheral testbenches.

## Interface
- `SETUP_CYCLES`, default 2: cycles that `usb_write` and the data bus are valid before the strobe falls; legal range 1..15.
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent waiting on any single `usb_wait` edge; must be ≥ 4.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted on a cycle where `cmd_valid && cmd_ready`.
- `cmd_type`  in  2  0 = WRITE_ADDR, 1 = READ_ADDR, 2 = WRITE_DATA, 3 = READ_DATA.
- `cmd_data`  in  8  write payload; ignored for reads.
- `rsp_valid`  out  1  one-cycle pulse when a command finishes.
- `rsp_data`  out  8  read byte; 0 for writes and timeouts.
- `rsp_timeout`  out  1  qualifies `rsp_valid`; set when the command was aborted.
- `usb_write`  out  1  EPP direction; low = host write.
- `usb_astb`  out  1  address strobe, active low.
- `usb_dstb`  out  1  data strobe, active low.
- `usb_db_out`  out  8  data bus drive value.
- `usb_db_oe`  out  1  data bus output enable; the top level builds the tristate.
- `usb_db_in`  in  8  data bus sampled value.
- `usb_wait`  in  1  peripheral wait, asynchronous to `clk`.

## Operation
- `usb_wait` passes through a 2-flop synchronizer to produce `wait_s`. Both flops reset to 1, so the peripheral is treated as busy until its wait line is seen low.
- `cmd_ready` = (state == IDLE) && !wait_s. It is a combinational output.
- A command is latched on acceptance. Its strobe is `usb_astb` for types 0 and 1, `usb_dstb` for types 2 and 3. It is a write for types 0 and 2.
- States:
  - IDLE: all outputs at their idle values. On accept, go to SETUP.
  - SETUP: `usb_write` = !is_write. For writes, `usb_db_out` = cmd_data and `usb_db_oe` = 1. Hold for SETUP_CYCLES cycles, then go to STROBE.
  - STROBE: the selected strobe is low. When wait_s = 1: for reads, capture `usb_db_in` into `rsp_data`; go to RECOVER. If the timeout counter reaches TIMEOUT_CYCLES, go to DONE with timeout.
  - RECOVER: the strobe is high; write data and `usb_write` are held. When wait_s = 0, go to DONE. On timeout, go to DONE with timeout.
  - DONE: `rsp_valid` = 1 for one cycle, `usb_db_oe` = 0, `usb_write` = 1. Go to IDLE.
- The timeout counter clears on entry to STROBE and to RECOVER and saturates at TIMEOUT_CYCLES. Its width is clog2(TIMEOUT_CYCLES+1).
- On a timeout, `rsp_data` = 0 and `rsp_timeout` = 1. The strobe is released the cycle after the timeout is detected.
- The bus is never driven during reads (`usb_db_oe` = 0 throughout).
- `cmd_valid` while busy is ignored; there is no queue.

## Timing
- Reset values: `usb_write`=1, `usb_astb`=1, `usb_dstb`=1, `usb_db_oe`=0, `usb_db_out`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_timeout`=0, `cmd_ready`=0, state=IDLE.
- Accept edge is T0:
  - `usb_write` and the data bus are valid from T0+1.
  - The strobe falls at T0+1+SETUP_CYCLES.
- `usb_wait` to internal response: 2 cycles of synchronizer latency, plus one cycle for the state change.
- A zero-delay peripheral gives a command duration of SETUP_CYCLES + 7 cycles from accept to `rsp_valid`.
- `cmd_ready` rises the cycle after `rsp_valid`, provided wait_s = 0. Back-to-back commands are therefore separated by at least one IDLE cycle.
- `rsp_data` and `rsp_timeout` stay stable until the next `rsp_valid`.
- Reset asserted mid-command:
  - All outputs return to their reset values immediately and asynchronously.
  - No `rsp_valid` is issued for the aborted command.

## Structure
- Package `epp_pkg` holds:
  - the `cmd_type` encoding constants (WRITE_ADDR..READ_DATA), shared with the peripheral driver;
  - the state enum (IDLE, SETUP, STROBE, RECOVER, DONE).
- Sub-module `sync_2ff` (parameterized reset value) implements the `usb_wait` synchronizer. It is reused wherever an EPP input crosses into `clk`.

## Test plan
- WRITE_ADDR 0x5A against a responsive peripheral model:
  - `usb_astb` low, `usb_write` low, `usb_db_out` = 0x5A with `usb_db_oe` = 1 before the strobe falls.
  - Model latches 0x5A; `rsp_valid` with `rsp_timeout` = 0.
- READ_DATA with the model returning 0xA5: `usb_dstb` low, `usb_write` high, `usb_db_oe` = 0 throughout; `rsp_data` = 0xA5.
- Model never raises wait, TIMEOUT_CYCLES = 8: strobe released after 8 STROBE cycles; `rsp_valid` with `rsp_timeout` = 1 and `rsp_data` = 0.
- Model holds wait high after strobe release: timeout from RECOVER; `rsp_timeout` = 1; `cmd_ready` stays 0 until wait drops.
- `cmd_valid` held high for 3 commands, model delay 5 cycles:
  - Exactly 3 accepts, each followed by exactly one `rsp_valid`.
  - Strobe-to-strobe spacing is ≥ SETUP_CYCLES + 7.
- `rst` pulsed while in STROBE: strobe goes high in the same cycle and no `rsp_valid` appears; the next command completes normally.

Source files
------------

// File: rtl/usb_epp_host_pkg.sv
// Shared EPP definitions: command encodings (also used by the peripheral driver)
// and the host engine state encoding.
package epp_pkg;

    localparam logic [1:0] CMD_WRITE_ADDR = 2'd0;
    localparam logic [1:0] CMD_READ_ADDR  = 2'd1;
    localparam logic [1:0] CMD_WRITE_DATA = 2'd2;
    localparam logic [1:0] CMD_READ_DATA  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER,
        DONE
    } epp_state_e;

    // Bit 0 of the encoding selects read, bit 1 selects the data strobe.
    function automatic logic cmd_is_write(input logic [1:0] t);
        return !t[0];
    endfunction

    function automatic logic cmd_is_addr(input logic [1:0] t);
        return !t[1];
    endfunction

endpackage

// File: rtl/usb_epp_host_if.sv
// EPP port signals; master is the host engine, slave is the peripheral side.
interface usb_epp_host_if;
    logic       usb_write;
    logic       usb_astb;
    logic       usb_dstb;
    logic [7:0] usb_db_out;
    logic       usb_db_oe;
    logic [7:0] usb_db_in;
    logic       usb_wait;

    modport master (
        output usb_write, usb_astb, usb_dstb, usb_db_out, usb_db_oe,
        input  usb_db_in, usb_wait
    );

    modport slave (
        input  usb_write, usb_astb, usb_dstb, usb_db_out, usb_db_oe,
        output usb_db_in, usb_wait
    );
endinterface

// File: rtl/usb_epp_host_sync_2ff.sv
// Two-flop synchronizer for a single EPP input entering the clk domain;
// RESET_VAL chooses what the line is assumed to be before it is first seen.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/usb_epp_host.sv
// EPP host engine: runs one address/data read or write per command on the
// Digilent EPP port and reports read data or a timeout.
module usb_epp_host
    import epp_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_type,
    input  logic [7:0]      cmd_data,
    output logic            rsp_valid,
    output logic [7:0]      rsp_data,
    output logic            rsp_timeout,
    usb_epp_host_if.master  epp
);

    localparam int             TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX     = TO_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]      SETUP_LAST = 4'(SETUP_CYCLES - 1);

    epp_state_e      state;
    epp_state_e      next_state;
    logic            wait_s;
    logic            accept;
    logic            timeout_evt;
    logic [1:0]      type_q;
    logic [7:0]      data_q;
    logic [7:0]      rd_buf;
    logic [3:0]      setup_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            is_write;

    // Busy until the wait line has actually been observed low.
    sync_2ff #(.RESET_VAL(1'b1)) u_wait_sync (
        .clk (clk),
        .rst (rst),
        .d   (epp.usb_wait),
        .q   (wait_s)
    );

    assign cmd_ready = (state == IDLE) && !wait_s;
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (state == DONE);
    assign is_write  = cmd_is_write(type_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A wait edge seen on the last allowed cycle still wins over the timeout.
    always_comb begin
        next_state  = state;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                if (accept) next_state = SETUP;
            end
            SETUP: begin
                if (setup_cnt == SETUP_LAST) next_state = STROBE;
            end
            STROBE: begin
                if (wait_s) begin
                    next_state = RECOVER;
                end else if (to_cnt == TO_LAST) begin
                    next_state  = DONE;
                    timeout_evt = 1'b1;
                end
            end
            RECOVER: begin
                if (!wait_s) begin
                    next_state = DONE;
                end else if (to_cnt == TO_LAST) begin
                    next_state  = DONE;
                    timeout_evt = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Counters restart on every state entry, so each wait edge gets its own budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            setup_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            if (state == SETUP && next_state == SETUP) begin
                setup_cnt <= setup_cnt + 4'd1;
            end else begin
                setup_cnt <= '0;
            end
            if (next_state != state) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Response registers only move on entry to DONE so they hold between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q      <= '0;
            data_q      <= '0;
            rd_buf      <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                type_q <= cmd_type;
                data_q <= cmd_data;
            end
            if (state == STROBE && wait_s && !is_write) begin
                rd_buf <= epp.usb_db_in;
            end
            if (next_state == DONE && state != DONE) begin
                rsp_timeout <= timeout_evt;
                rsp_data    <= (timeout_evt || is_write) ? 8'h00 : rd_buf;
            end
        end
    end

    always_comb begin
        epp.usb_write  = 1'b1;
        epp.usb_astb   = 1'b1;
        epp.usb_dstb   = 1'b1;
        epp.usb_db_oe  = 1'b0;
        epp.usb_db_out = 8'h00;
        if (state == SETUP || state == STROBE || state == RECOVER) begin
            epp.usb_write  = !is_write;
            epp.usb_db_oe  = is_write;
            epp.usb_db_out = is_write ? data_q : 8'h00;
        end
        if (state == STROBE) begin
            if (cmd_is_addr(type_q)) begin
                epp.usb_astb = 1'b0;
            end else begin
                epp.usb_dstb = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_epp_host.sv
// Directed bench for usb_epp_host with a simple EPP peripheral model whose
// wait response can be delayed, suppressed or held high.
module tb_usb_epp_host;
    import epp_pkg::*;

    localparam int SETUP    = 2;
    localparam int TIMEOUT  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;

    int checks   = 0;
    int failures = 0;

    usb_epp_host_if bus ();

    usb_epp_host #(
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .epp         (bus)
    );

    always #5 clk = ~clk;

    // Peripheral model: raises wait model_delay cycles after the strobe falls.
    int         model_delay = 0;
    logic       model_never = 1'b0;
    logic       model_hold  = 1'b0;
    logic [7:0] model_rdata = 8'h00;
    logic [7:0] model_addr  = 8'h00;
    logic [7:0] model_data  = 8'h00;
    int         mcnt        = 0;
    logic       held        = 1'b0;
    logic       strobe_low;
    logic       raise;

    assign strobe_low    = !bus.usb_astb || !bus.usb_dstb;
    assign raise         = strobe_low && !model_never && (mcnt >= model_delay);
    assign bus.usb_wait  = raise || (model_hold && held);
    assign bus.usb_db_in = model_rdata;

    always @(posedge clk) begin
        mcnt <= strobe_low ? mcnt + 1 : 0;
        held <= model_hold && (held || raise);
        if (raise && !bus.usb_write && bus.usb_db_oe) begin
            if (!bus.usb_astb) model_addr <= bus.usb_db_out;
            else               model_data <= bus.usb_db_out;
        end
    end

    // Observations gathered by applyStimulus, cycle numbers relative to accept.
    logic       ob_accepted;
    int         ob_rsp_cyc;
    int         ob_fall_cyc;
    int         ob_low_cnt;
    logic       ob_c1_write, ob_c1_oe, ob_fall_write, ob_fall_oe, ob_oe_any, ob_wrong, ob_rsp_to;
    logic [7:0] ob_c1_out, ob_fall_out, ob_rsp_data;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] t, input logic [7:0] d, input int limit);
        logic sel, other;
        ob_accepted = 1'b0;
        ob_rsp_cyc  = -1;
        ob_fall_cyc = -1;
        ob_low_cnt  = 0;
        ob_oe_any   = 1'b0;
        ob_wrong    = 1'b0;
        ob_fall_write = 1'b1;
        ob_fall_oe  = 1'b0;
        ob_fall_out = 8'h00;
        ob_rsp_to   = 1'b0;
        ob_rsp_data = 8'h00;
        cmd_type  = t;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !ob_accepted; i++) begin
            if (cmd_ready) ob_accepted = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        if (ob_accepted) begin
            for (int k = 1; k <= limit; k++) begin
                sel   = t[1] ? bus.usb_dstb : bus.usb_astb;
                other = t[1] ? bus.usb_astb : bus.usb_dstb;
                if (bus.usb_db_oe) ob_oe_any = 1'b1;
                if (!other) ob_wrong = 1'b1;
                if (k == 1) begin
                    ob_c1_write = bus.usb_write;
                    ob_c1_oe    = bus.usb_db_oe;
                    ob_c1_out   = bus.usb_db_out;
                end
                if (!sel) begin
                    ob_low_cnt++;
                    if (ob_fall_cyc < 0) begin
                        ob_fall_cyc   = k;
                        ob_fall_write = bus.usb_write;
                        ob_fall_oe    = bus.usb_db_oe;
                        ob_fall_out   = bus.usb_db_out;
                    end
                end
                if (rsp_valid) begin
                    ob_rsp_cyc  = k;
                    ob_rsp_data = rsp_data;
                    ob_rsp_to   = rsp_timeout;
                    break;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int   accepts, rsps, outstanding, order_bad, last_fall, min_space, rsp_seen;
        logic prev_high, drop, acc, found;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 2'd0;
        cmd_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_write",   bus.usb_write,  1);
        checkOutput("rst_astb",    bus.usb_astb,   1);
        checkOutput("rst_dstb",    bus.usb_dstb,   1);
        checkOutput("rst_oe",      bus.usb_db_oe,  0);
        checkOutput("rst_db_out",  bus.usb_db_out, 0);
        checkOutput("rst_rsp_vld", rsp_valid,      0);
        checkOutput("rst_rsp_dat", rsp_data,       0);
        checkOutput("rst_rsp_to",  rsp_timeout,    0);
        checkOutput("rst_ready",   cmd_ready,      0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_sync1", cmd_ready, 0);
        @(posedge clk); #1;
        checkOutput("ready_sync2", cmd_ready, 1);

        $display("[TB] WRITE_ADDR 0x5A, responsive peripheral");
        applyStimulus(CMD_WRITE_ADDR, 8'h5A, 40);
        checkOutput("wa_accept",    ob_accepted,   1);
        checkOutput("wa_c1_write",  ob_c1_write,   0);
        checkOutput("wa_c1_oe",     ob_c1_oe,      1);
        checkOutput("wa_c1_out",    ob_c1_out,     8'h5A);
        checkOutput("wa_fall_cyc",  ob_fall_cyc,   SETUP + 1);
        checkOutput("wa_fall_out",  ob_fall_out,   8'h5A);
        checkOutput("wa_fall_oe",   ob_fall_oe,    1);
        checkOutput("wa_low_cnt",   ob_low_cnt,    3);
        checkOutput("wa_wrong_stb", ob_wrong,      0);
        checkOutput("wa_rsp_cyc",   ob_rsp_cyc,    SETUP + 7);
        checkOutput("wa_rsp_to",    ob_rsp_to,     0);
        checkOutput("wa_rsp_data",  ob_rsp_data,   0);
        checkOutput("wa_model",     model_addr,    8'h5A);
        @(posedge clk); #1;
        checkOutput("wa_ready_after", cmd_ready, 1);
        checkOutput("wa_rsp_pulse",   rsp_valid, 0);

        $display("[TB] READ_DATA returning 0xA5");
        model_rdata = 8'hA5;
        applyStimulus(CMD_READ_DATA, 8'hFF, 40);
        checkOutput("rd_fall_cyc",   ob_fall_cyc,   SETUP + 1);
        checkOutput("rd_fall_write", ob_fall_write, 1);
        checkOutput("rd_oe_any",     ob_oe_any,     0);
        checkOutput("rd_wrong_stb",  ob_wrong,      0);
        checkOutput("rd_rsp_cyc",    ob_rsp_cyc,    SETUP + 7);
        checkOutput("rd_rsp_data",   ob_rsp_data,   8'hA5);
        checkOutput("rd_rsp_to",     ob_rsp_to,     0);
        @(posedge clk); #1;
        checkOutput("rd_data_hold",  rsp_data,      8'hA5);

        $display("[TB] peripheral never raises wait");
        model_never = 1'b1;
        applyStimulus(CMD_WRITE_DATA, 8'h77, 40);
        checkOutput("to_fall_cyc",  ob_fall_cyc, SETUP + 1);
        checkOutput("to_low_cnt",   ob_low_cnt,  TIMEOUT);
        checkOutput("to_rsp_cyc",   ob_rsp_cyc,  SETUP + 1 + TIMEOUT);
        checkOutput("to_rsp_to",    ob_rsp_to,   1);
        checkOutput("to_rsp_data",  ob_rsp_data, 0);
        checkOutput("to_dstb_rel",  bus.usb_dstb, 1);
        model_never = 1'b0;
        @(posedge clk); #1;
        checkOutput("to_ready_after", cmd_ready, 1);

        $display("[TB] wait held high after strobe release");
        model_hold  = 1'b1;
        model_rdata = 8'hC3;
        applyStimulus(CMD_READ_ADDR, 8'h00, 40);
        checkOutput("rc_low_cnt",  ob_low_cnt,  3);
        checkOutput("rc_rsp_cyc",  ob_rsp_cyc,  14);
        checkOutput("rc_rsp_to",   ob_rsp_to,   1);
        checkOutput("rc_rsp_data", ob_rsp_data, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rc_ready_held", cmd_ready, 0);
        model_hold = 1'b0;
        @(posedge clk); #1;
        checkOutput("rc_ready_sync", cmd_ready, 0);
        @(posedge clk); #1;
        checkOutput("rc_ready_free", cmd_ready, 1);

        $display("[TB] cmd_valid held for three commands, delay 5");
        model_delay = 5;
        accepts = 0; rsps = 0; outstanding = 0; order_bad = 0;
        last_fall = -1; min_space = 1000; prev_high = 1'b1; drop = 1'b0;
        cmd_type  = CMD_WRITE_DATA;
        cmd_data  = 8'h11;
        cmd_valid = 1'b1;
        for (int k = 0; k < 70; k++) begin
            if (rsp_valid) begin
                rsps++;
                if (outstanding != 1 || rsp_timeout) order_bad++;
                outstanding = 0;
            end
            if (prev_high && !bus.usb_dstb) begin
                if (last_fall >= 0 && (k - last_fall) < min_space) min_space = k - last_fall;
                last_fall = k;
            end
            prev_high = bus.usb_dstb;
            if (cmd_valid && cmd_ready) begin
                accepts++;
                if (outstanding != 0) order_bad++;
                outstanding = 1;
                if (accepts == 3) drop = 1'b1;
            end
            @(posedge clk); #1;
            if (drop) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        checkOutput("b2b_accepts",   accepts,   3);
        checkOutput("b2b_rsps",      rsps,      3);
        checkOutput("b2b_order",     order_bad, 0);
        checkOutput("b2b_spacing",   min_space >= SETUP + 7, 1);
        checkOutput("b2b_model",     model_data, 8'h11);

        $display("[TB] reset pulsed during STROBE");
        cmd_type  = CMD_WRITE_DATA;
        cmd_data  = 8'h99;
        cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            if (cmd_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        checkOutput("rs_accept", acc, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (!bus.usb_dstb) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checkOutput("rs_strobe_seen", found, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("rs_dstb",    bus.usb_dstb,  1);
        checkOutput("rs_write",   bus.usb_write, 1);
        checkOutput("rs_oe",      bus.usb_db_oe, 0);
        checkOutput("rs_rsp_vld", rsp_valid,     0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid) rsp_seen++;
            @(posedge clk); #1;
        end
        checkOutput("rs_no_rsp",  rsp_seen,   0);
        checkOutput("rs_model",   model_data, 8'h11);
        model_delay = 0;
        applyStimulus(CMD_WRITE_ADDR, 8'h3C, 40);
        checkOutput("rs_next_rsp_cyc", ob_rsp_cyc, SETUP + 7);
        checkOutput("rs_next_rsp_to",  ob_rsp_to,  0);
        checkOutput("rs_next_model",   model_addr, 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
